audio_recorder: RTL and testbench

- Capture block that records 8-bit ADC samples at the audio sample rate into a writable sample RAM.
- It is the write-side counterpart of the ROM-based audio player.
- Button-driven start and stop; stops automatically when memory is full.
- The player side later reads back the stored take at the same SAMPLE_RATE.

---
 rtl/audio_pkg.sv | 18 +
 rtl/sample_tick_gen.sv | 34 +++
 rtl/audio_recorder.sv | 155 +++++++++++++++
 tb/tb_audio_recorder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture and playback blocks.
//   state_t              : recorder state encoding (IDLE, REC, DONE)
//   ADC_MIDSCALE         : sample value that represents silence for the unsigned 8-bit ADC
//   DEFAULT_CLK_FREQ     : system clock frequency in Hz used by recorder and player
//   DEFAULT_SAMPLE_RATE  : audio sample rate in Hz used by recorder and player
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  ADC_MIDSCALE        = 8'h80;
  localparam int unsigned DEFAULT_CLK_FREQ    = 100_000_000;
  localparam int unsigned DEFAULT_SAMPLE_RATE = 11_025;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period tick generator shared by the audio recorder and player.
// Counts 0..COUNTER_MAX-1 while enabled and raises tick for the single cycle
// in which the count sits at COUNTER_MAX-1.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : count enable
//   clr  : synchronous clear of the count (next cycle starts at 0)
//   tick : single-cycle sample strobe
module sample_tick_gen #(
  parameter int unsigned COUNTER_MAX = 9070
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (COUNTER_MAX > 1) ? $clog2(COUNTER_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNTER_MAX - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/audio_recorder.sv
// Audio capture block: records 8-bit ADC samples at SAMPLE_RATE into a sample RAM.
//   clk, rst      : system clock, synchronous active-high reset
//   rec_button    : async pushbutton, rising edge starts or restarts a take
//   stop_button   : async pushbutton, rising edge ends the take
//   adc_valid     : one-cycle ADC conversion strobe
//   adc_data      : unsigned ADC sample, valid with adc_valid
//   mem_we        : single-cycle RAM write enable
//   mem_addr      : RAM write address (meaningful while mem_we=1)
//   mem_wdata     : RAM write data (meaningful while mem_we=1)
//   recording     : high while recording
//   done          : high once a take has completed
//   sample_count  : samples written in the current or last take (saturates at DEPTH)
//   stale         : sticky, some sample period in this take had no fresh ADC data
module audio_recorder
  import audio_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int unsigned SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned COUNTER_MAX = CLK_FREQ / SAMPLE_RATE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_button,
  input  logic              stop_button,
  input  logic              adc_valid,
  input  logic [7:0]        adc_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              recording,
  output logic              done,
  output logic [ADDR_W:0]   sample_count,
  output logic              stale
);

  // Count value at which the last address of the RAM is being written.
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  state_t      state, state_n;
  logic [1:0]  rec_sync, stop_sync;
  logic        rec_prev, stop_prev;
  logic        rec_pulse, stop_pulse;
  logic [7:0]  held;
  logic        fresh;
  logic        tick;
  logic        start;
  logic        do_write;
  logic [7:0]  sample_value;
  logic        sample_fresh;

  assign rec_pulse  = rec_sync[1]  & ~rec_prev;
  assign stop_pulse = stop_sync[1] & ~stop_prev;

  // A strobe arriving in the tick cycle itself is written directly and counts as fresh.
  assign sample_value = adc_valid ? adc_data : held;
  assign sample_fresh = fresh | adc_valid;

  assign recording = (state == REC);
  assign done      = (state == DONE);

  sample_tick_gen #(
    .COUNTER_MAX (COUNTER_MAX)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state == REC),
    .clr  (start),
    .tick (tick)
  );

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    do_write = 1'b0;
    case (state)
      IDLE: begin
        if (rec_pulse) begin
          start   = 1'b1;
          state_n = REC;
        end
      end
      REC: begin
        // Restart wins over stop and discards a coincident tick.
        if (rec_pulse) begin
          start = 1'b1;
        end else begin
          if (tick) begin
            do_write = 1'b1;
            if (sample_count == LAST_IDX) state_n = DONE;
          end
          if (stop_pulse) state_n = DONE;
        end
      end
      DONE: begin
        if (rec_pulse) begin
          start   = 1'b1;
          state_n = REC;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rec_sync  <= '0;
      stop_sync <= '0;
      rec_prev  <= 1'b0;
      stop_prev <= 1'b0;
    end else begin
      state     <= state_n;
      rec_sync  <= {rec_sync[0], rec_button};
      stop_sync <= {stop_sync[0], stop_button};
      rec_prev  <= rec_sync[1];
      stop_prev <= stop_sync[1];
    end
  end

  // ADC capture runs in every state; a write consumes the held sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      held  <= ADC_MIDSCALE;
      fresh <= 1'b0;
    end else begin
      if (adc_valid) held <= adc_data;
      if (do_write)       fresh <= 1'b0;
      else if (adc_valid) fresh <= 1'b1;
    end
  end

  // Write port: address and data only change when a write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      sample_count <= '0;
      stale        <= 1'b0;
    end else begin
      mem_we <= do_write;
      if (start) begin
        sample_count <= '0;
        stale        <= 1'b0;
      end else if (do_write) begin
        mem_addr     <= sample_count[ADDR_W-1:0];
        mem_wdata    <= sample_value;
        sample_count <= sample_count + 1'b1;
        if (!sample_fresh) stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_recorder.sv
// Self-checking bench for audio_recorder with COUNTER_MAX=10 and DEPTH=8.
module tb_audio_recorder;

  localparam int unsigned CLK_FREQ    = 100;
  localparam int unsigned SAMPLE_RATE = 10;
  localparam int unsigned ADDR_W      = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              rec_button;
  logic              stop_button;
  logic              adc_valid;
  logic [7:0]        adc_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              recording;
  logic              done;
  logic [ADDR_W:0]   sample_count;
  logic              stale;

  always #5 clk = ~clk;

  audio_recorder #(
    .CLK_FREQ    (CLK_FREQ),
    .SAMPLE_RATE (SAMPLE_RATE),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rec_button   (rec_button),
    .stop_button  (stop_button),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .recording    (recording),
    .done         (done),
    .sample_count (sample_count),
    .stale        (stale)
  );

  typedef struct {
    bit         valid;
    logic [7:0] data;
    logic [7:0] exp_wdata;
    int         exp_count;
    bit         exp_stale;
    bit         exp_done;
  } vec_t;

  vec_t       tbl [8];
  int         vecs = 0;
  int         errs = 0;
  int         cyc = 0;
  int         take_writes = 0;
  int         last_wr_cyc = -1;
  int         first_wr_cyc = -1;
  int         press_cyc = 0;
  int         total_we = 0;
  int         snap;
  int         k;
  bit         auto_adc = 1'b0;
  bit         saw_we = 1'b0;
  logic [7:0] next_data = 8'h10;
  logic [7:0] model_held = 8'h80;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, check any write, then drive inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    saw_we = mem_we;
    if (mem_we) begin
      chk("wr_addr", int'(mem_addr), take_writes);
      chk("wr_data", int'(mem_wdata), int'(model_held));
      if (last_wr_cyc >= 0) chk("wr_gap", cyc - last_wr_cyc, 10);
      else first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      take_writes++;
      total_we++;
    end
    if (auto_adc) begin
      adc_valid  = 1'b1;
      adc_data   = next_data;
      model_held = next_data;
      next_data  = next_data + 8'd1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_we(input string name);
    int n;
    step();
    n = 1;
    while (!saw_we && n < 40) begin
      step();
      n++;
    end
    if (!saw_we) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic new_take();
    take_writes  = 0;
    last_wr_cyc  = -1;
    first_wr_cyc = -1;
    press_cyc    = cyc;
  endtask

  task automatic press_rec();
    rec_button = 1'b1;
    new_take();
    run(3);
    rec_button = 1'b0;
    run(1);
  endtask

  task automatic press_stop();
    stop_button = 1'b1;
    run(3);
    stop_button = 1'b0;
    run(1);
  endtask

  task automatic do_reset();
    auto_adc  = 1'b0;
    adc_valid = 1'b0;
    rst       = 1'b1;
    step();
    model_held = 8'h80;
    rst        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 8'h00, 8'h80, 1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h33, 8'h33, 2, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 8'h33, 3, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 8'hFF, 4, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h00, 8'h00, 5, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 6, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'h7F, 8'h7F, 7, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'h81, 8'h81, 8, 1'b1, 1'b1};

    rst         = 1'b1;
    rec_button  = 1'b0;
    stop_button = 1'b0;
    adc_valid   = 1'b0;
    adc_data    = 8'h00;

    // Reset state and idle
    run(3);
    chk("rst_we",    int'(mem_we), 0);
    chk("rst_addr",  int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_rec",   int'(recording), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_count", int'(sample_count), 0);
    chk("rst_stale", int'(stale), 0);
    rst = 1'b0;
    run(50);
    chk("idle_we_total", total_we, 0);
    chk("idle_rec",      int'(recording), 0);
    chk("idle_count",    int'(sample_count), 0);

    // Full take with fresh data every cycle
    auto_adc = 1'b1;
    rec_button = 1'b1;
    new_take();
    run(2);
    chk("rec_edge2", int'(recording), 0);
    run(1);
    chk("rec_edge3", int'(recording), 1);
    rec_button = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      step();
      k++;
    end
    chk("full_done",      int'(done), 1);
    chk("full_writes",    take_writes, 8);
    chk("first_latency",  first_wr_cyc - press_cyc, 13);
    chk("done_at_last",   last_wr_cyc, cyc);
    chk("full_count",     int'(sample_count), 8);
    chk("full_stale",     int'(stale), 0);
    chk("full_rec",       int'(recording), 0);
    snap = total_we;
    run(20);
    chk("full_no_extra",  total_we, snap);

    // Stop after the third write
    press_rec();
    k = 0;
    while (take_writes < 3 && k < 100) begin
      step();
      k++;
    end
    press_stop();
    chk("stop_done",  int'(done), 1);
    chk("stop_count", int'(sample_count), 3);
    snap = total_we;
    run(30);
    chk("stop_no_extra", total_we, snap);
    press_stop();
    chk("stop2_done",  int'(done), 1);
    chk("stop2_count", int'(sample_count), 3);
    chk("stop2_rec",   int'(recording), 0);
    chk("stop2_we",    total_we, snap);

    // No ADC data after reset, then per-period table of strobes
    do_reset();
    run(2);
    press_rec();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].valid) begin
        adc_valid  = 1'b1;
        adc_data   = tbl[i].data;
        model_held = tbl[i].data;
        step();
        adc_valid = 1'b0;
      end
      wait_we("tbl_wait");
      chk("tbl_wdata", int'(mem_wdata), int'(tbl[i].exp_wdata));
      chk("tbl_count", int'(sample_count), tbl[i].exp_count);
      chk("tbl_stale", int'(stale), int'(tbl[i].exp_stale));
      chk("tbl_done",  int'(done), int'(tbl[i].exp_done));
    end
    run(20);
    chk("stale_held_done", int'(stale), 1);
    auto_adc = 1'b1;
    press_rec();
    chk("stale_cleared", int'(stale), 0);
    chk("newtake_rec",   int'(recording), 1);
    chk("newtake_done",  int'(done), 0);
    chk("newtake_count", int'(sample_count), 0);

    // Stop pulse landing on a tick
    wait_we("s5_first");
    run(7);
    stop_button = 1'b1;
    run(2);
    chk("tickstop_early", int'(done), 0);
    run(1);
    stop_button = 1'b0;
    chk("tickstop_we",    int'(saw_we), 1);
    chk("tickstop_done",  int'(done), 1);
    chk("tickstop_count", int'(sample_count), 2);
    snap = total_we;
    run(15);
    chk("tickstop_no_extra", total_we, snap);

    // Rec and stop together while recording
    press_rec();
    wait_we("s5b_first");
    rec_button  = 1'b1;
    stop_button = 1'b1;
    new_take();
    run(3);
    rec_button  = 1'b0;
    stop_button = 1'b0;
    chk("both_rec",   int'(recording), 1);
    chk("both_done",  int'(done), 0);
    chk("both_count", int'(sample_count), 0);
    wait_we("both_first");
    chk("both_latency", first_wr_cyc - press_cyc, 13);
    chk("both_addr0",   int'(mem_addr), 0);

    // Reset mid-take after two writes
    wait_we("s6_second");
    chk("s6_count", int'(sample_count), 2);
    do_reset();
    chk("midrst_rec",   int'(recording), 0);
    chk("midrst_done",  int'(done), 0);
    chk("midrst_count", int'(sample_count), 0);
    chk("midrst_we",    int'(mem_we), 0);
    chk("midrst_stale", int'(stale), 0);
    snap = total_we;
    run(30);
    chk("midrst_no_we", total_we, snap);
    auto_adc = 1'b1;
    press_rec();
    wait_we("after_rst");
    chk("after_rst_addr",  int'(mem_addr), 0);
    chk("after_rst_count", int'(sample_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
